// File: rtl/sample_gearbox_if.sv
// sample_gearbox_if: squeeze-word input handshake and chunk output bundle for
// the sample_gearbox regrouping stage.
//   Din        [63:0]  squeeze word, Din[7:0] is the earliest byte
//   Din_valid          Din holds a valid word
//   Din_ready          gearbox takes Din this cycle
//   Dout       [55:0]  7-byte chunk, Dout[7:0] is the earliest byte
//   Dout_flag          Dout valid for this cycle only
//   block_done         one-cycle pulse on the last word of a rate block
//   chunk_cnt  [15:0]  emitted-chunk counter (only with GEARBOX_CHUNK_CNT_EN)
// master = word producer / chunk consumer side, slave = the gearbox.
interface sample_gearbox_if;
  logic [63:0] Din;
  logic        Din_valid;
  logic        Din_ready;
  logic [55:0] Dout;
  logic        Dout_flag;
  logic        block_done;
`ifdef GEARBOX_CHUNK_CNT_EN
  logic [15:0] chunk_cnt;

  modport master (output Din, Din_valid,
                  input  Din_ready, Dout, Dout_flag, block_done, chunk_cnt);
  modport slave  (input  Din, Din_valid,
                  output Din_ready, Dout, Dout_flag, block_done, chunk_cnt);
`else
  modport master (output Din, Din_valid,
                  input  Din_ready, Dout, Dout_flag, block_done);
  modport slave  (input  Din, Din_valid,
                  output Din_ready, Dout, Dout_flag, block_done);
`endif
endinterface

// File: rtl/sample_gearbox.sv
// sample_gearbox: regroups 64-bit SHAKE squeeze words into 56-bit chunks for
// the 49-bit rejection sampler. Bytes are kept little-endian, oldest first, in
// a 15-byte buffer; one chunk leaves per cycle whenever 7 bytes are held.
// A word counter marks the end of each SHAKE rate block.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   clr  - synchronous clear of buffer, fill and word counter
//   gb   - sample_gearbox_if.slave (Din/Din_valid/Din_ready in,
//          Dout/Dout_flag/block_done out, plus chunk_cnt when enabled)
//
// Optional build macro GEARBOX_CHUNK_CNT_EN adds a saturating 16-bit count of
// emitted chunks on gb.chunk_cnt.
module sample_gearbox #(
  parameter int RATE_WORDS = 21,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  sample_gearbox_if.slave  gb
);

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(RATE_WORDS - 1);

  logic [119:0]     byte_buf_p0;
  logic [3:0]       fill_p0;
  logic [CNT_W-1:0] wcnt_p0;

  logic [55:0]      dout_p1;
  logic             vld_p1;
  logic             block_done_p1;

  logic             emit;
  logic             din_ready;
  logic             accept;
  logic             wrap;
  logic [3:0]       base;
  logic [3:0]       fill_nxt;
  logic [119:0]     buf_nxt;

`ifdef GEARBOX_CHUNK_CNT_EN
  logic [15:0]      chunk_cnt_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Stage p0: buffer state -> emit/accept decision and next buffer image.
  // Din_ready depends on registers only, so it never loops back through
  // Din_valid. With emit, up to 14 held bytes still leave room for a word
  // after the shift-out; without emit the append alone must fit.
  always_comb begin
    emit      = (fill_p0 >= 4'd7);
    din_ready = emit ? (fill_p0 <= 4'd14) : (fill_p0 <= 4'd7);
    accept    = gb.Din_valid & din_ready;
    wrap      = (wcnt_p0 == WCNT_LAST);
    base      = emit ? (fill_p0 - 4'd7) : fill_p0;
    fill_nxt  = base + (accept ? 4'd8 : 4'd0);
    buf_nxt   = emit ? {56'd0, byte_buf_p0[119:56]} : byte_buf_p0;
    // base never exceeds 7 on an accept, so the word always lands in bytes 0..14.
    if (accept) begin
      buf_nxt = buf_nxt | ({56'd0, gb.Din} << {base, 3'b000});
    end
  end

  // Stage p1: registered chunk output, block marker and chunk counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_buf_p0   <= '0;
      fill_p0       <= '0;
      wcnt_p0       <= '0;
      dout_p1       <= '0;
      vld_p1        <= 1'b0;
      block_done_p1 <= 1'b0;
`ifdef GEARBOX_CHUNK_CNT_EN
      chunk_cnt_p1  <= '0;
`endif
    end else if (clr) begin
      byte_buf_p0   <= '0;
      fill_p0       <= '0;
      wcnt_p0       <= '0;
      dout_p1       <= '0;
      vld_p1        <= 1'b0;
      block_done_p1 <= 1'b0;
`ifdef GEARBOX_CHUNK_CNT_EN
      chunk_cnt_p1  <= '0;
`endif
    end else begin
      byte_buf_p0   <= buf_nxt;
      fill_p0       <= fill_nxt;
      dout_p1       <= emit ? byte_buf_p0[55:0] : 56'd0;
      vld_p1        <= emit;
      block_done_p1 <= accept & wrap;
      if (accept) begin
        wcnt_p0 <= wrap ? '0 : wcnt_p0 + CNT_W'(1);
      end
`ifdef GEARBOX_CHUNK_CNT_EN
      if (emit) begin
        chunk_cnt_p1 <= sat_inc16(chunk_cnt_p1);
      end
`endif
    end
  end

  assign gb.Din_ready  = din_ready;
  assign gb.Dout       = dout_p1;
  assign gb.Dout_flag  = vld_p1;
  assign gb.block_done = block_done_p1;
`ifdef GEARBOX_CHUNK_CNT_EN
  assign gb.chunk_cnt  = chunk_cnt_p1;
`endif

endmodule

// File: tb/tb_sample_gearbox.sv
// tb_sample_gearbox: scoreboard bench for sample_gearbox. Accepted words feed
// a byte-stream model that queues expected 7-byte chunks; a monitor pops the
// queue on every Dout_flag. Directed words carry hand-computed chunk values.
module tb_sample_gearbox;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  sample_gearbox_if gif ();

  sample_gearbox dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .gb  (gif)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          chunks_seen = 0;
  int          stalls = 0;
  int          wcnt_m = 0;
  int          last_drop = 0;
  logic [55:0] last_dout = '0;
  logic [55:0] exp_q[$];
  logic [7:0]  bq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every chunk the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst && gif.Dout_flag) begin
      chunks_seen++;
      last_dout = gif.Dout;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL chunk_unexpected: got %0h expected none", gif.Dout);
      end else begin
        check("chunk", gif.Dout, exp_q.pop_front());
      end
    end
  end

  // Byte-stream model: the sampler must see the input bytes in order, 7 at a time.
  task automatic model_accept(input logic [63:0] w, output logic wrap);
    logic [55:0] c;
    for (int j = 0; j < 8; j++) bq.push_back(w[8*j +: 8]);
    while (bq.size() >= 7) begin
      for (int k = 0; k < 7; k++) c[8*k +: 8] = bq.pop_front();
      exp_q.push_back(c);
    end
    wcnt_m++;
    wrap = (wcnt_m == 21);
    if (wrap) wcnt_m = 0;
  endtask

  // One clock: inputs applied just after a falling edge, outputs checked 1 unit
  // after the next falling edge (the monitor has already run by then).
  task automatic cycle(input logic v, input logic [63:0] w, input logic c, output logic acc);
    logic rdy;
    logic wrap;
    gif.Din       = w;
    gif.Din_valid = v;
    clr           = c;
    rdy           = gif.Din_ready;
    if (v && !rdy) stalls++;
    @(posedge clk);
    acc  = v && rdy;
    wrap = 1'b0;
    if (c) begin
      last_drop = exp_q.size();
      bq.delete();
      exp_q.delete();
      wcnt_m = 0;
    end else if (acc) begin
      model_accept(w, wrap);
    end
    @(negedge clk);
    #1;
    check("block_done", gif.block_done, wrap);
    if (c) check("clr_flag", gif.Dout_flag, 1'b0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b0, acc);
  endtask

  task automatic do_clr();
    logic acc;
    cycle(1'b0, 64'd0, 1'b1, acc);
  endtask

  task automatic send_word(input logic [63:0] w);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 10) begin
      cycle(1'b1, w, 1'b0, acc);
      tries++;
    end
    check("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [63:0] pat(input int k, input int b0);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'((b0 + 8*k + j) & 255);
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_chunks;
    rst           = 1'b0;
    clr           = 1'b0;
    gif.Din       = '0;
    gif.Din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dout", gif.Dout, 56'd0);
    check("rst_flag", gif.Dout_flag, 1'b0);
    check("rst_block_done", gif.block_done, 1'b0);
    check("rst_ready", gif.Din_ready, 1'b1);
    rst = 1'b1;

    // Single word: first chunk two edges after the accepting edge, 1 byte left.
    send_word(64'h0807060504030201);
    check("lat_early_flag", gif.Dout_flag, 1'b0);
    idle(1);
    check("lat_flag", gif.Dout_flag, 1'b1);
    check("lat_dout", gif.Dout, 56'h07060504030201);
    idle(3);
    check("w1_chunks", chunks_seen, 1);
    check("w1_quiet", gif.Dout_flag, 1'b0);

    // Second word joins the held byte 0x08; 2 bytes remain afterwards.
    send_word(64'h100F0E0D0C0B0A09);
    idle(1);
    check("w2_dout", gif.Dout, 56'h0E0D0C0B0A0908);
    idle(3);
    check("w2_chunks", chunks_seen, 2);

    // Full rate block after clr: block_done on the 21st word (wcnt cleared by clr).
    // Fill climbs 8..15 between stalls, so 21 back-to-back words see two stalls.
    do_clr();
    base_chunks = chunks_seen;
    stalls      = 0;
    for (int k = 0; k < 21; k++) send_word(pat(k, 8'h20));
    drain();
    idle(3);
    check("blk_chunks", chunks_seen - base_chunks, 24);
    check("blk_stalls", stalls, 2);
    check("blk_last", last_dout, 56'hC7C6C5C4C3C2C1);

    // clr at fill = 10 with a word on the bus: the pending chunk and the word are lost.
    base_chunks = chunks_seen;
    send_word(64'h3736353433323130);
    send_word(64'h3F3E3D3C3B3A3938);
    send_word(64'h4746454443424140);
    begin
      logic acc;
      cycle(1'b1, 64'h4F4E4D4C4B4A4948, 1'b1, acc);
    end
    check("clr_drop", last_drop, 1);
    idle(3);
    check("clr_chunks", chunks_seen - base_chunks, 2);
    send_word(64'h7766554433221100);
    idle(2);
    check("clr_restart", last_dout, 56'h66554433221100);

    // Asynchronous reset at fill = 12 while a chunk is on Dout.
    do_clr();
    for (int k = 0; k < 5; k++) send_word(pat(k, 8'h80));
    check("pre_rst_flag", gif.Dout_flag, 1'b1);
    gif.Din_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("arst_dout", gif.Dout, 56'd0);
    check("arst_flag", gif.Dout_flag, 1'b0);
    check("arst_block_done", gif.block_done, 1'b0);
    check("arst_ready", gif.Din_ready, 1'b1);
    bq.delete();
    exp_q.delete();
    wcnt_m = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    base_chunks = chunks_seen;
    idle(2);
    check("post_rst_quiet", chunks_seen - base_chunks, 0);
    send_word(64'hF7F6F5F4F3F2F1F0);
    idle(2);
    check("post_rst_dout", last_dout, 56'hF6F5F4F3F2F1F0);
    check("post_rst_chunks", chunks_seen - base_chunks, 1);

`ifdef GEARBOX_CHUNK_CNT_EN
    do_clr();
    check("ccnt_clr0", gif.chunk_cnt, 16'd0);
    for (int k = 0; k < 42; k++) send_word(pat(k, 8'h05));
    drain();
    check("ccnt_48", gif.chunk_cnt, 16'd48);
    do_clr();
    check("ccnt_clr", gif.chunk_cnt, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
